sr_cfg_sequencer: RTL and testbench

Sequences one TMIIa shift-register configuration transaction on top of `Top_SR`, in the same `clk` domain. For each host command it:
- drives `din` and pulses `start` into `Top_SR`;
- captures the old register contents returned on `dout`/`valid`;
- optionally shifts the same word a second time, so the readback can be compared against what was written;
- returns a single response with the old contents, the match flag, the mismatch count and the timeout status.

---
 rtl/sr_cfg_sequencer_pkg.sv | 23 ++
 rtl/sr_cfg_sequencer_if.sv | 43 ++++
 rtl/sr_seq_bitcount.sv | 53 +++++
 rtl/sr_cfg_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sr_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_cfg_sequencer_pkg.sv
// sr_cfg_sequencer shared types and constants.
// State encoding plus default widths and derived limits.
package sr_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START1,
    S_WAIT1,
    S_START2,
    S_WAIT2,
    S_COUNT,
    S_RESP
  } state_t;

  localparam int SR_WIDTH     = 170;
  localparam int SR_CNT_WIDTH = 8;
  localparam int SR_TO_WIDTH  = 16;

  localparam int SR_ERR_WIDTH = SR_CNT_WIDTH + 1;

  localparam logic [SR_TO_WIDTH-1:0] SR_TO_MAX = '1;

endpackage

// File: rtl/sr_cfg_sequencer_if.sv
// Host command/response and Top_SR bundle for sr_cfg_sequencer.
// slave: sequencer side; master: host plus Top_SR side.
interface sr_cfg_sequencer_if
  import sr_cfg_sequencer_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter int CNT_WIDTH = SR_CNT_WIDTH
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_data;
  logic                 cmd_verify;

  logic                 sr_start;
  logic [WIDTH-1:0]     sr_din;
  logic                 sr_valid;
  logic [WIDTH-1:0]     sr_dout;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_old;
  logic                 rsp_match;
  logic [CNT_WIDTH:0]   rsp_err_cnt;
  logic                 rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_data, cmd_verify,
    input  sr_valid, sr_dout, rsp_ready,
    output cmd_ready, sr_start, sr_din,
    output rsp_valid, rsp_old, rsp_match,
    output rsp_err_cnt, rsp_timeout
  );

  modport master (
    output cmd_valid, cmd_data, cmd_verify,
    output sr_valid, sr_dout, rsp_ready,
    input  cmd_ready, sr_start, sr_din,
    input  rsp_valid, rsp_old, rsp_match,
    input  rsp_err_cnt, rsp_timeout
  );

endinterface

// File: rtl/sr_seq_bitcount.sv
// Serial popcount: load a word, then one bit per step.
// Ports: clk, rst, load/data, step, last (final bit now), cnt.
module sr_seq_bitcount
  import sr_cfg_sequencer_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter int CNT_WIDTH = SR_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     data,
  input  logic                 step,
  output logic                 last,
  output logic [CNT_WIDTH:0]   cnt
);

  logic [WIDTH-1:0]     diff_q, diff_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      diff_q <= diff_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  // The word shifts right so bit idx_q is always at diff_q[0].
  always_comb begin
    diff_d = diff_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (load) begin
      diff_d = data;
      idx_d  = '0;
      cnt_d  = '0;
    end else if (step) begin
      diff_d = diff_q >> 1;
      idx_d  = idx_q + CNT_WIDTH'(1);
      cnt_d  = cnt_q + (CNT_WIDTH + 1)'(diff_q[0]);
    end
  end

  assign last = (idx_q == CNT_WIDTH'(WIDTH - 1));
  assign cnt  = cnt_q;

endmodule

// File: rtl/sr_cfg_sequencer.sv
// One Top_SR config transaction per host command, optional verify.
// Ports: clk, rst (sync, high), bus (slave). Macro SR_SEQ_ERRCNT_EN.
module sr_cfg_sequencer
  import sr_cfg_sequencer_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter int CNT_WIDTH = SR_CNT_WIDTH,
  parameter int TO_WIDTH  = SR_TO_WIDTH
) (
  input logic               clk,
  input logic               rst,
  sr_cfg_sequencer_if.slave bus
);

  localparam logic [TO_WIDTH-1:0] TO_MAX = '1;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    din_q, din_d;
  logic                verify_q, verify_d;
  logic [WIDTH-1:0]    old_q, old_d;
  logic                match_q, match_d;
  logic                tmo_q, tmo_d;
  logic [TO_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [TO_WIDTH-1:0] tcnt_inc;
  logic                sv_q;
  logic                sv_rise;

`ifdef SR_SEQ_ERRCNT_EN
  localparam int EW = CNT_WIDTH + 1;

  logic             bc_load;
  logic             bc_step;
  logic             bc_last;
  logic [WIDTH-1:0] bc_data;
  logic [EW-1:0]    bc_cnt;

  sr_seq_bitcount #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bitcount (
    .clk  (clk),
    .rst  (rst),
    .load (bc_load),
    .data (bc_data),
    .step (bc_step),
    .last (bc_last),
    .cnt  (bc_cnt)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      din_q    <= '0;
      verify_q <= 1'b0;
      old_q    <= '0;
      match_q  <= 1'b0;
      tmo_q    <= 1'b0;
      tcnt_q   <= '0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      verify_q <= verify_d;
      old_q    <= old_d;
      match_q  <= match_d;
      tmo_q    <= tmo_d;
      tcnt_q   <= tcnt_d;
      sv_q     <= bus.sr_valid;
    end
  end

  // A level still high from the last shift must not count.
  assign sv_rise  = bus.sr_valid & ~sv_q;
  assign tcnt_inc = tcnt_q + TO_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    verify_d = verify_q;
    old_d    = old_q;
    match_d  = match_q;
    tmo_d    = tmo_q;
    tcnt_d   = tcnt_q;
`ifdef SR_SEQ_ERRCNT_EN
    bc_load  = 1'b0;
    bc_step  = 1'b0;
    bc_data  = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          din_d    = bus.cmd_data;
          verify_d = bus.cmd_verify;
          match_d  = 1'b0;
          tmo_d    = 1'b0;
`ifdef SR_SEQ_ERRCNT_EN
          // Loading zero clears the previous error count.
          bc_load  = 1'b1;
`endif
          state_d  = S_START1;
        end
      end
      S_START1: begin
        tcnt_d  = '0;
        state_d = S_WAIT1;
      end
      S_START2: begin
        tcnt_d  = '0;
        state_d = S_WAIT2;
      end
      S_WAIT1: begin
        if (sv_rise) begin
          old_d   = bus.sr_dout;
          state_d = verify_q ? S_START2 : S_RESP;
        end else if (tcnt_inc == TO_MAX) begin
          tcnt_d  = tcnt_inc;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d  = tcnt_inc;
        end
      end
      S_WAIT2: begin
        if (sv_rise) begin
          match_d = ((bus.sr_dout ^ din_q) == '0);
`ifdef SR_SEQ_ERRCNT_EN
          bc_load = 1'b1;
          bc_data = bus.sr_dout ^ din_q;
          state_d = S_COUNT;
`else
          state_d = S_RESP;
`endif
        end else if (tcnt_inc == TO_MAX) begin
          tcnt_d  = tcnt_inc;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d  = tcnt_inc;
        end
      end
`ifdef SR_SEQ_ERRCNT_EN
      S_COUNT: begin
        bc_step = 1'b1;
        if (bc_last) begin
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = (state_q == S_IDLE);
    bus.sr_start    = (state_q == S_START1) |
                      (state_q == S_START2);
    bus.sr_din      = din_q;
    bus.rsp_valid   = (state_q == S_RESP);
    bus.rsp_old     = old_q;
    bus.rsp_match   = match_q;
    bus.rsp_timeout = tmo_q;
`ifdef SR_SEQ_ERRCNT_EN
    bus.rsp_err_cnt = bc_cnt;
`else
    bus.rsp_err_cnt = {(CNT_WIDTH + 1){1'b0}};
`endif
  end

endmodule

// File: tb/tb_sr_cfg_sequencer.sv
// Testbench for sr_cfg_sequencer with a behavioural Top_SR.
// Vector table plus timeout, stale-valid and reset sequences.
module tb_sr_cfg_sequencer;
  import sr_cfg_sequencer_pkg::*;

  localparam int W    = 170;
  localparam int EW   = SR_ERR_WIDTH;
  localparam int TO_W = 16;
  localparam int LAT  = 5;
  localparam int NV   = 6;
`ifdef SR_SEQ_ERRCNT_EN
  localparam logic ERRC = 1'b1;
`else
  localparam logic ERRC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_cfg_sequencer_if #(.WIDTH(W), .CNT_WIDTH(8)) bus ();

  sr_cfg_sequencer #(
    .WIDTH     (W),
    .CNT_WIDTH (8),
    .TO_WIDTH  (TO_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Top_SR model: after LAT cycles returns old contents,
  // raises valid and keeps it high until the next start.
  logic         mdl_en   = 1'b1;
  logic [W-1:0] mdl_flip = '0;
  logic         ovr      = 1'b0;
  logic         ovr_valid = 1'b0;
  logic [W-1:0] ovr_dout = '0;
  int           n_starts = 0;
  int           base     = 0;
  logic [W-1:0] contents = '0;
  logic         busy     = 1'b0;
  int           cd       = 0;
  int           pidx     = 0;
  logic         m_valid  = 1'b0;
  logic [W-1:0] m_dout   = '0;

  assign bus.sr_valid = ovr ? ovr_valid : m_valid;
  assign bus.sr_dout  = ovr ? ovr_dout : m_dout;

  always @(posedge clk) begin
    if (bus.sr_start) n_starts <= n_starts + 1;
    if (rst) begin
      contents <= '0;
      busy     <= 1'b0;
      cd       <= 0;
      m_valid  <= 1'b0;
      m_dout   <= '0;
    end else if (bus.sr_start && mdl_en) begin
      busy    <= 1'b1;
      cd      <= LAT;
      m_valid <= 1'b0;
      pidx    <= n_starts - base + 1;
    end else if (busy) begin
      if (cd == 0) begin
        m_dout   <= contents ^ ((pidx == 2) ? mdl_flip : '0);
        contents <= bus.sr_din;
        m_valid  <= 1'b1;
        busy     <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic reset_check(string p);
    chkb({p, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chkb({p, "_sr_start"}, bus.sr_start, 1'b0);
    chkb({p, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chkb({p, "_match"}, bus.rsp_match, 1'b0);
    chkb({p, "_timeout"}, bus.rsp_timeout, 1'b0);
    chk({p, "_sr_din"}, bus.sr_din, '0);
    chk({p, "_old"}, bus.rsp_old, '0);
    chk({p, "_err"}, W'(bus.rsp_err_cnt), '0);
  endtask

  // Returns #1 after the accepting edge (DUT in START1).
  task automatic send_cmd(logic [W-1:0] d, logic v);
    bit got;
    got = 1'b0;
    @(negedge clk);
    base           = n_starts;
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = d;
    bus.cmd_verify = v;
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL cmd_accept: cmd_ready 0 want 1");
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(string nm, int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chkb({nm, "_rsp_seen"}, got, 1'b1);
  endtask

  task automatic accept_rsp(string nm);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chkb({nm, "_ready_back"}, bus.cmd_ready, 1'b1);
  endtask

  typedef struct {
    logic [W-1:0]  data;
    logic          verify;
    logic [W-1:0]  flip;
    logic [W-1:0]  old;
    logic          match;
    logic [EW-1:0] err;
    int            starts;
  } vec_t;

  vec_t vec [NV];

  logic [W-1:0] p_a, p_5, p_ff, p_flip3, p_flip1;
  logic [W-1:0] dead;
  int           n;
  bit           seen;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    p_a = '0;
    for (int i = 1; i < W; i += 2) p_a[i] = 1'b1;
    p_5     = ~p_a;
    p_ff    = '1;
    dead    = W'(32'hDEAD_BEEF);
    p_flip3 = '0;
    p_flip3[0]   = 1'b1;
    p_flip3[85]  = 1'b1;
    p_flip3[169] = 1'b1;
    p_flip1 = '0;
    p_flip1[169] = 1'b1;

    vec[0] = '{p_a, 1'b1, '0, '0, 1'b1,
               '0, 2};
    vec[1] = '{p_5, 1'b1, p_flip3, p_a, 1'b0,
               ERRC ? EW'(3) : '0, 2};
    vec[2] = '{W'(1), 1'b0, '0, p_5, 1'b0,
               '0, 1};
    vec[3] = '{dead, 1'b0, '0, W'(1), 1'b0,
               '0, 1};
    vec[4] = '{p_ff, 1'b1, p_flip1, dead, 1'b0,
               ERRC ? EW'(1) : '0, 2};
    vec[5] = '{'0, 1'b1, '0, p_ff, 1'b1,
               '0, 2};

    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = '0;
    bus.cmd_verify = 1'b0;
    bus.rsp_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_check("rst");

    for (int i = 0; i < NV; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      mdl_flip = vec[i].flip;
      send_cmd(vec[i].data, vec[i].verify);
      wait_rsp(nm, 2000);
      chk({nm, "_old"}, bus.rsp_old, vec[i].old);
      chkb({nm, "_match"}, bus.rsp_match, vec[i].match);
      chk({nm, "_err"}, W'(bus.rsp_err_cnt),
          W'(vec[i].err));
      chkb({nm, "_timeout"}, bus.rsp_timeout, 1'b0);
      chki({nm, "_starts"}, n_starts - base,
           vec[i].starts);
      chk({nm, "_sr_din"}, bus.sr_din, vec[i].data);
      accept_rsp(nm);
    end
    mdl_flip = '0;

    // Timeout: model ignores start, valid never rises.
    mdl_en = 1'b0;
    send_cmd(dead, 1'b1);
    chkb("to_start", bus.sr_start, 1'b1);
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < int'(SR_TO_MAX) + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.rsp_timeout) seen = 1'b1;
    end
    chkb("to_seen", seen, 1'b1);
    chki("to_cycles", n, (1 << TO_W) - 1);
    chkb("to_valid", bus.rsp_valid, 1'b1);
    chkb("to_match", bus.rsp_match, 1'b0);
    chk("to_err", W'(bus.rsp_err_cnt), '0);
    chki("to_starts", n_starts - base, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chkb("to_hold", bus.rsp_valid, 1'b1);
    end
    accept_rsp("to");

    // Stale valid: level high before the command.
    @(negedge clk);
    ovr       = 1'b1;
    ovr_valid = 1'b1;
    ovr_dout  = p_5;
    repeat (3) @(negedge clk);
    send_cmd(W'(7), 1'b0);
    repeat (20) @(negedge clk);
    chkb("stale_nocap", bus.rsp_valid, 1'b0);
    chki("stale_starts", n_starts - base, 1);
    ovr_valid = 1'b0;
    @(negedge clk);
    ovr_dout      = dead;
    ovr_valid     = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chkb("stale_rsp", bus.rsp_valid, 1'b1);
    chk("stale_old", bus.rsp_old, dead);
    @(negedge clk);
    chkb("stale_1cyc_ready", bus.cmd_ready, 1'b1);
    chkb("stale_1cyc_valid", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
    ovr    = 1'b0;
    mdl_en = 1'b1;

    // Reset while waiting on the second pass.
    send_cmd(p_a, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_starts - base == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chkb("wrst_in_wait2", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_check("wrst");
    send_cmd(p_5, 1'b1);
    wait_rsp("after", 2000);
    chk("after_old", bus.rsp_old, '0);
    chkb("after_match", bus.rsp_match, 1'b1);
    chk("after_err", W'(bus.rsp_err_cnt), '0);
    chki("after_starts", n_starts - base, 2);
    accept_rsp("after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
